// File: rtl/adc_write_controller.sv
// ADC capture write controller: arms on an empty FIFO, waits for a trigger, then writes
// CAPTURE_LEN decimated samples into the sample FIFO and waits for the FIFO to drain.
module adc_write_controller #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CAPTURE_LEN = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              arm,
    input  logic              trigger,
    input  logic              abort,
    input  logic [7:0]        decim,
    input  logic              full,
    input  logic              empty,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              capture_done,
    output logic              overflow
);

    localparam int unsigned CntW = $clog2(CAPTURE_LEN + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(CAPTURE_LEN - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StFill, StWaitDrain} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   sample_cnt_q, sample_cnt_d;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              eligible;

    // >= rather than == keeps the counter bounded if decim is lowered mid-capture
    assign eligible = adc_valid && (dec_cnt_q >= decim);

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        dec_cnt_d    = dec_cnt_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm && empty) begin
                        state_d    = StArmed;
                        overflow_d = 1'b0;
                    end
                end
                StArmed: begin
                    if (trigger) begin
                        state_d      = StFill;
                        sample_cnt_d = '0;
                        dec_cnt_d    = '0;
                    end
                end
                StFill: begin
                    if (adc_valid) begin
                        dec_cnt_d = eligible ? 8'd0 : dec_cnt_q + 8'd1;
                    end
                    if (eligible) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            wr_en_d      = 1'b1;
                            wr_data_d    = adc_data;
                            sample_cnt_d = sample_cnt_q + CntW'(1);
                            if (sample_cnt_q == LastIdx) begin
                                done_d  = 1'b1;
                                state_d = StWaitDrain;
                            end
                        end
                    end
                end
                StWaitDrain: begin
                    if (empty) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sample_cnt_q <= '0;
            dec_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            dec_cnt_q    <= dec_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;
    assign capture_done = done_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_adc_write_controller.sv
// Self-checking bench for adc_write_controller: directed vector table, directed capture
// sequences and a randomized run, all checked against a behavioural capture model.
module tb_adc_write_controller;

    localparam int DW  = 16;
    localparam int LEN = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    decim = 8'd0;
    logic          full = 1'b0;
    logic          empty = 1'b1;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          capture_done;
    logic          overflow;

    adc_write_controller #(
        .DATA_W      (DW),
        .CAPTURE_LEN (LEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .arm          (arm),
        .trigger      (trigger),
        .abort        (abort),
        .decim        (decim),
        .full         (full),
        .empty        (empty),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .busy         (busy),
        .capture_done (capture_done),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: capture lifecycle as flags plus "samples kept" / "valid since keep"
    bit            m_armed, m_filling, m_draining;
    int            m_written, m_skip;
    bit            m_wr_en, m_done, m_ovf;
    logic [DW-1:0] m_wr_data;

    function automatic void model_update();
        m_wr_en = 1'b0;
        m_done  = 1'b0;
        if (rst) begin
            m_armed = 0; m_filling = 0; m_draining = 0;
            m_written = 0; m_skip = 0; m_ovf = 0; m_wr_data = '0;
        end else if (abort) begin
            m_armed = 0; m_filling = 0; m_draining = 0;
        end else if (m_filling) begin
            if (adc_valid) begin
                if (m_skip == int'(decim)) begin
                    m_skip = 0;
                    if (full) m_ovf = 1;
                    else begin
                        m_wr_en = 1; m_wr_data = adc_data; m_written++;
                        if (m_written == LEN) begin
                            m_done = 1; m_filling = 0; m_draining = 1;
                        end
                    end
                end else begin
                    m_skip++;
                end
            end
        end else if (m_armed) begin
            if (trigger) begin
                m_armed = 0; m_filling = 1; m_written = 0; m_skip = 0;
            end
        end else if (m_draining) begin
            if (empty) m_draining = 0;
        end else if (arm && empty) begin
            m_armed = 1; m_ovf = 0;
        end
    endfunction

    // Statistics observed on DUT outputs for the directed sequences
    int            s_wr, s_done, s_done_wr;
    logic [DW-1:0] s_first, s_last;

    task automatic clear_stats();
        s_wr = 0; s_done = 0; s_done_wr = -1; s_first = '0; s_last = '0;
    endtask

    // One clock: advance model, clock DUT, compare every output
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, m_wr_en);
        chk("wr_data", wr_data, m_wr_data);
        chk("busy", busy, m_armed | m_filling | m_draining);
        chk("capture_done", capture_done, m_done);
        chk("overflow", overflow, m_ovf);
        if (wr_en) begin
            s_wr++;
            if (s_wr == 1) s_first = wr_data;
            s_last = wr_data;
        end
        if (capture_done) begin
            s_done++;
            s_done_wr = wr_en ? s_wr : -1;
        end
    endtask

    task automatic go_fill(input logic [7:0] d);
        abort = 0; arm = 1; empty = 1; step(); arm = 0;
        decim = d; trigger = 1; adc_valid = 1; adc_data = '0; step(); trigger = 0;
        empty = 0;
        clear_stats();
    endtask

    typedef struct {
        logic          rst, arm, trigger, abort, valid, full, empty;
        logic [DW-1:0] data;
        logic [7:0]    decim;
        logic          e_wr_en;
        logic [DW-1:0] e_wr_data;
        logic          e_busy, e_done, e_ovf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             rst arm trg abt vld ful emp data     dec  wr  wdata    bsy dn  ovf
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 1, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 0, 1, 0, 1, 16'hAAAA, 0, 0, 16'h0000, 1, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 1, 0, 0, 16'h1234, 0, 1, 16'h1234, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 16'h4321, 0, 0, 16'h1234, 1, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 1, 1, 0, 16'h5678, 0, 0, 16'h1234, 1, 0, 1};
        vecs[8]  = '{0, 1, 1, 0, 1, 0, 0, 16'h9ABC, 0, 1, 16'h9ABC, 1, 0, 1};
        vecs[9]  = '{0, 0, 0, 1, 1, 0, 0, 16'h1111, 0, 0, 16'h9ABC, 0, 0, 1};
        vecs[10] = '{0, 1, 0, 0, 0, 0, 1, 16'h2222, 0, 0, 16'h9ABC, 1, 0, 0};
        vecs[11] = '{1, 1, 1, 0, 1, 0, 1, 16'h3333, 0, 0, 16'h0000, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; arm = vecs[i].arm; trigger = vecs[i].trigger;
            abort = vecs[i].abort; adc_valid = vecs[i].valid; full = vecs[i].full;
            empty = vecs[i].empty; adc_data = vecs[i].data; decim = vecs[i].decim;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].e_wr_en);
            chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].e_wr_data);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_capture_done", i), capture_done, vecs[i].e_done);
            chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].e_ovf);
        end

        // Sync model with DUT through a reset
        rst = 1; arm = 0; trigger = 0; abort = 0; adc_valid = 0; full = 0; empty = 1;
        step(); rst = 0;

        // Basic full capture with ramp data
        go_fill(8'd0);
        for (int i = 1; i < LEN + 20 && s_done == 0; i++) begin
            adc_data = DW'(i);
            step();
        end
        chk("basic_writes", s_wr, LEN);
        chk("basic_first", s_first, 1);
        chk("basic_last", s_last, LEN);
        chk("basic_done_cnt", s_done, 1);
        chk("basic_done_on_last", s_done_wr, LEN);
        arm = 1; trigger = 1;
        for (int i = 0; i < 5; i++) step();
        arm = 0; trigger = 0;
        chk("drain_busy", busy, 1);
        chk("drain_no_writes", s_wr, LEN);
        empty = 1; step();
        chk("drain_idle", busy, 0);
        empty = 0; arm = 1; step(); arm = 0;
        chk("arm_not_empty", busy, 0);

        // Decimation by 4
        go_fill(8'd3);
        for (int i = 0; i < 40; i++) begin adc_data = DW'($urandom); step(); end
        chk("decim_40_valid", s_wr, 10);
        begin
            int nv = 0;
            clear_stats();
            for (int i = 0; i < 100; i++) begin
                adc_valid = ($urandom_range(2) != 0);
                if (adc_valid) nv++;
                adc_data = DW'($urandom);
                step();
            end
            chk("decim_gaps", s_wr, nv / 4);
        end
        adc_valid = 1; abort = 1; step(); abort = 0;

        // Overflow: five dropped eligible samples mid-capture
        go_fill(8'd0);
        for (int i = 1; i < LEN + 50 && s_done == 0; i++) begin
            adc_data = DW'(i);
            full = (i >= 1000 && i < 1005);
            step();
        end
        full = 0;
        chk("ovf_writes", s_wr, LEN);
        chk("ovf_last", s_last, LEN + 5);
        chk("ovf_sticky", overflow, 1);
        empty = 1; step();
        chk("ovf_after_drain", overflow, 1);
        arm = 1; step(); arm = 0;
        chk("ovf_cleared_by_arm", overflow, 0);
        abort = 1; step(); abort = 0;

        // Abort after 100 writes
        go_fill(8'd0);
        for (int i = 1; i < 200 && s_wr < 100; i++) begin adc_data = DW'(i); step(); end
        chk("abort_pre_writes", s_wr, 100);
        abort = 1; step(); abort = 0;
        clear_stats();
        for (int i = 0; i < 10; i++) step();
        chk("abort_extra_le1", (s_wr <= 1), 1);
        chk("abort_no_done", s_done, 0);
        chk("abort_idle", busy, 0);

        // Reset after 100 writes
        go_fill(8'd0);
        for (int i = 1; i < 200 && s_wr < 100; i++) begin adc_data = DW'(i); step(); end
        rst = 1; step(); rst = 0;
        chk("rst_outputs", {wr_en, busy, capture_done, overflow}, 0);
        chk("rst_wr_data", wr_data, 0);
        clear_stats();
        for (int i = 0; i < 10; i++) step();
        chk("rst_no_writes", s_wr, 0);

        // Randomized run; decim only changes outside a fill
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(499) == 0);
            abort     = ($urandom_range(299) == 0);
            arm       = ($urandom_range(19) == 0);
            trigger   = ($urandom_range(19) == 0);
            adc_valid = ($urandom_range(3) != 0);
            full      = ($urandom_range(9) == 0);
            empty     = ($urandom_range(1) == 0);
            adc_data  = DW'($urandom);
            if (!m_filling && $urandom_range(9) == 0) decim = 8'($urandom_range(3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_write_controller.md
ADC_WRITE_CONTROLLER -- requirements
Module: adc_write_controller

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 16, ADC sample width in bits.
REQ-002 The block SHALL expose parameter CAPTURE_LEN, default 4096, samples written per capture; equals sample FIFO depth.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 adc_data  input  DATA_W  ADC sample.
REQ-006 adc_valid  input  1  adc_data valid this cycle.
REQ-007 arm  input  1  request a new capture.
REQ-008 trigger  input  1  start filling once armed.
REQ-009 abort  input  1  cancel capture immediately.
REQ-010 decim  input  8  decimation ratio; keep 1 of every decim+1 valid samples.
REQ-011 full  input  1  sample FIFO full flag.
REQ-012 empty  input  1  sample FIFO empty flag.
REQ-013 wr_en  output  1  FIFO write strobe, registered.
REQ-014 wr_data  output  DATA_W  FIFO write data, registered.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 capture_done  output  1  one-cycle pulse on final write of a capture.
REQ-017 overflow  output  1  sticky: eligible sample dropped because FIFO was full.

Function
REQ-018 The FSM SHALL have states IDLE, ARMED, FILL, WAIT_DRAIN, with busy and all outputs driven from registered state and registered datapath.
REQ-019 IDLE: arm=1 with empty=1 SHALL move to ARMED and clear overflow; arm=1 with empty=0 SHALL be ignored.
REQ-020 ARMED: trigger=1 SHALL move to FILL and clear the sample counter and decimation counter; the sample on the trigger cycle SHALL NOT be written.
REQ-021 FILL: each adc_valid=1 cycle SHALL be eligible when decimation counter == decim, then counter resets to 0; otherwise counter increments; adc_valid=0 leaves counter unchanged.
REQ-022 decim=0 SHALL make every valid sample eligible; decimation counter SHALL be 8 bits and never exceed decim.
REQ-023 An eligible sample seen with full=0 at cycle N SHALL produce wr_en=1 and wr_data=that sample at cycle N+1 (latency 1), and increment the sample counter.
REQ-024 An eligible sample seen with full=1 SHALL be dropped, SHALL set overflow, and SHALL NOT increment the sample counter.
REQ-025 The write of sample CAPTURE_LEN SHALL assert capture_done in the same cycle as its wr_en, and FILL SHALL move to WAIT_DRAIN on that edge; no further writes occur.
REQ-026 Sample counter width SHALL be clog2(CAPTURE_LEN+1) and SHALL never exceed CAPTURE_LEN.
REQ-027 WAIT_DRAIN: empty=1 SHALL return to IDLE; arm and trigger SHALL be ignored.
REQ-028 arm in ARMED, FILL or WAIT_DRAIN, and trigger outside ARMED, SHALL be ignored.
REQ-029 abort=1 in any state SHALL return to IDLE next edge; a write already registered at that edge SHALL complete, none afterwards; capture_done SHALL NOT assert; overflow SHALL be retained.
REQ-030 abort and arm together in IDLE: abort SHALL take priority, staying IDLE.
REQ-031 In all cycles without a qualifying write, wr_en SHALL be 0; wr_data SHALL hold its last value.

Reset
REQ-032 rst=1 SHALL force state IDLE and clear sample counter, decimation counter, wr_en, wr_data, busy, capture_done, overflow to 0 on the next edge, overriding all other inputs.
REQ-033 rst asserted mid-FILL SHALL stop writes from the following cycle; no capture_done.

Verification
REQ-034 Basic: empty=1, arm, trigger, decim=0, adc_valid=1 continuous, data ramp 0,1,2...; full=0 -> exactly 4096 wr_en pulses, wr_data 1..4096 (ramp offset by trigger-cycle sample), capture_done with write 4096, busy until empty=1.
REQ-035 Decimation: decim=3, adc_valid=1 every cycle -> one write per 4 valid samples; adc_valid gaps do not advance the counter.
REQ-036 Overflow: force full=1 for 5 eligible samples mid-FILL -> 5 drops, overflow=1 sticky, capture still completes 4096 writes; next accepted arm clears overflow.
REQ-037 Arm gating: arm with empty=0 -> remains IDLE, busy=0; arm in WAIT_DRAIN -> ignored.
REQ-038 Abort/reset: abort after 100 writes -> at most 1 further wr_en, IDLE, no capture_done; repeat with rst -> all outputs 0 next cycle.
